// File: rtl/weakmem_pkg.sv
// weakmem_pkg: shared FSM encoding, wait-counter width and LFSR constants
// for the weakmem bus responder.
package weakmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam int unsigned WCNT_W = 5;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/weakmem_lfsr.sv
// weakmem_lfsr: free-running 16-bit Fibonacci LFSR used to randomise wait
// states. Only instantiated when WEAKMEM_RANDWAIT_EN is defined.
module weakmem_lfsr
  import weakmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  // advance every cycle; seeded on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_next(lfsr_q);
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/weakmem.sv
// weakmem: word-organised memory responder for the weakcore bus_* handshake.
// Reads, byte-masked writes, programmable wait states, one-cycle ack pulse.
// Optional macro WEAKMEM_RANDWAIT_EN adds 0..3 random extra wait states.
module weakmem
  import weakmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr,
  input  logic [3:0]  bus_wr_mask,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] wload;
  logic [31:0]       addr_q, wdata_q;
  logic              wr_q;
  logic [3:0]        mask_q;
  logic              ack_q;
  logic              rd_sel_q;
  logic [31:0]       mem_rd_q;
  logic [31:0]       mem_q [DEPTH];

  logic              go_ack;
  logic [31:0]       cur_addr, cur_wdata, off;
  logic              cur_wr;
  logic [3:0]        cur_mask;
  logic              hit;
  logic [AW-1:0]     idx;

`ifdef WEAKMEM_RANDWAIT_EN
  logic [15:0] lfsr;
  logic [13:0] unused_lfsr;

  weakmem_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  assign wload       = WCNT_W'(WAIT_CYCLES) + WCNT_W'(lfsr[1:0]);
  assign unused_lfsr = lfsr[15:2];
`else
  assign wload = WCNT_W'(WAIT_CYCLES);
`endif

  // next-state: IDLE accepts, WAIT counts down (abort on req drop), ACK returns
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    go_ack  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus_req) begin
          wcnt_d = wload;
          if (wload != '0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!bus_req) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == WCNT_W'(1)) begin
            state_d = S_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // zero-wait accesses complete on the IDLE edge, so they use the live request
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_addr  = bus_addr;
      cur_wr    = bus_wr;
      cur_mask  = bus_wr_mask;
      cur_wdata = bus_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_wr    = wr_q;
      cur_mask  = mask_q;
      cur_wdata = wdata_q;
    end
    off = cur_addr - BASE;
    hit = (cur_addr >= BASE) && ({1'b0, off} < SPAN);
    idx = off[AW+1:2];
  end

  // control state, request latch and registered ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      mask_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= go_ack;
      if (state_q == S_IDLE && bus_req) begin
        addr_q  <= bus_addr;
        wr_q    <= bus_wr;
        mask_q  <= bus_wr_mask;
        wdata_q <= bus_wdata;
      end
      if (go_ack) rd_sel_q <= !cur_wr && hit;
    end
  end

  // storage: byte-enable write, read-first port, contents never reset
  always_ff @(posedge clk) begin
    if (go_ack) begin
      if (cur_wr) begin
        if (hit) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (cur_mask[b]) mem_q[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
          end
        end
      end else begin
        mem_rd_q <= mem_q[idx];
      end
    end
  end

  // rd_sel_q zeroes write acks, out-of-range reads and the reset value
  assign bus_rdata = rd_sel_q ? mem_rd_q : '0;
  assign bus_ack   = ack_q;

endmodule

// File: tb/tb_weakmem.sv
// tb_weakmem: directed vector table plus hand-written sequences for two
// weakmem instances (zero-wait at BASE 0, three-wait at BASE 0x1000).
module tb_weakmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [3:0]  mask  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];

`ifdef WEAKMEM_RANDWAIT_EN
  localparam int RAND_EXTRA = 3;
`else
  localparam int RAND_EXTRA = 0;
`endif

  weakmem #(.DEPTH(16), .BASE(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus_req(req[0]), .bus_addr(addr[0]), .bus_wr(wr[0]),
    .bus_wr_mask(mask[0]), .bus_wdata(wdata[0]), .bus_rdata(rdata[0]), .bus_ack(ack[0])
  );

  weakmem #(.DEPTH(16), .BASE(32'h0000_1000), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .bus_req(req[1]), .bus_addr(addr[1]), .bus_wr(wr[1]),
    .bus_wr_mask(mask[1]), .bus_wdata(wdata[1]), .bus_rdata(rdata[1]), .bus_ack(ack[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // one full transaction: latency, one-cycle ack and returned data
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] wd,
                        output logic [31:0] rd);
    int lat;
    bit got;
    int base_w;
    lat    = 0;
    got    = 0;
    base_w = (d == 0) ? 0 : 3;
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; mask[d] = m; wdata[d] = wd;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) got = 1;
    end
    rd     = rdata[d];
    req[d] = 1'b0;
    wr[d]  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d addr %h: no ack within %0d cycles", d, a, lat);
      rd = 'x;
    end else begin
      chk_range("latency", lat, 1 + base_w, 1 + base_w + RAND_EXTRA);
      @(posedge clk); #1;
      chk("ack_width", 32'(ack[d]), 32'h0);
    end
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];
  logic [31:0] model [16];

  initial begin : main
    logic [31:0] rd;
    int acks;

    vt[0]  = '{0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{0, 1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{0, 1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0};
    vt[3]  = '{0, 1'b1, 32'h20,   4'h4, 32'hAABBCCDD, 32'h0};
    vt[4]  = '{0, 1'b0, 32'h20,   4'hF, 32'h0,        32'h11BB3344};
    vt[5]  = '{0, 1'b1, 32'h00,   4'hF, 32'h01020304, 32'h0};
    vt[6]  = '{0, 1'b1, 32'h40,   4'hF, 32'h5A5A5A5A, 32'h0};
    vt[7]  = '{0, 1'b0, 32'h40,   4'h0, 32'h0,        32'h0};
    vt[8]  = '{0, 1'b0, 32'h00,   4'h0, 32'h0,        32'h01020304};
    vt[9]  = '{0, 1'b1, 32'h10,   4'h0, 32'hFFFFFFFF, 32'h0};
    vt[10] = '{0, 1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    vt[11] = '{0, 1'b1, 32'h3C,   4'hF, 32'h76543210, 32'h0};
    vt[12] = '{0, 1'b1, 32'h3C,   4'h9, 32'hAAFFFFBB, 32'h0};
    vt[13] = '{0, 1'b0, 32'h3C,   4'h0, 32'h0,        32'hAA5432BB};
    vt[14] = '{0, 1'b0, 32'h44,   4'h0, 32'h0,        32'h0};
    vt[15] = '{1, 1'b1, 32'h1004, 4'hF, 32'hCAFEF00D, 32'h0};
    vt[16] = '{1, 1'b0, 32'h1004, 4'h0, 32'h0,        32'hCAFEF00D};
    vt[17] = '{1, 1'b1, 32'h103C, 4'hF, 32'h12345678, 32'h0};
    vt[18] = '{1, 1'b1, 32'h0FFC, 4'hF, 32'hFFFFFFFF, 32'h0};
    vt[19] = '{1, 1'b0, 32'h103C, 4'h0, 32'h0,        32'h12345678};
    vt[20] = '{1, 1'b0, 32'h0FFC, 4'h0, 32'h0,        32'h0};
    vt[21] = '{1, 1'b0, 32'h1040, 4'h0, 32'h0,        32'h0};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; mask[d] = '0; wdata[d] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'h0);
      chk("reset_rdata", rdata[d], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      access(vt[i].d, vt[i].w, vt[i].a, vt[i].m, vt[i].wd, rd);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end

`ifndef WEAKMEM_RANDWAIT_EN
    // req held continuously: ACK never chains, so acks every other cycle
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10; mask[0] = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", c), 32'(ack[0]), (c % 2 == 0) ? 32'h1 : 32'h0);
      if (c % 2 == 0) chk("b2b_rdata", rdata[0], 32'hDEADBEEF);
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_tail_ack", 32'(ack[0]), 32'h0);
`endif

    // req dropped during WAIT: no ack and the write is discarded
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h1004; mask[1] = 4'hF; wdata[1] = 32'h99999999;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    req[1] = 1'b0; wr[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    chk("abort_acks", 32'(acks), 32'h0);
    access(1, 1'b0, 32'h1004, 4'h0, 32'h0, rd);
    chk("abort_readback", rd, 32'hCAFEF00D);

    // reset two cycles into a waited write
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h1004; mask[1] = 4'hF; wdata[1] = 32'h0BADF00D;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    rst = 1'b0;
    #1;
    chk("rstmid_ack", 32'(ack[1]), 32'h0);
    chk("rstmid_rdata", rdata[1], 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
    end
    chk("rstmid_acks", 32'(acks), 32'h0);
    access(1, 1'b0, 32'h1004, 4'h0, 32'h0, rd);
    chk("rstmid_readback", rd, 32'hCAFEF00D);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
    chk("rst_keeps_mem", rd, 32'hDEADBEEF);

    // random accesses against a scoreboard, including out-of-range words
    for (int i = 0; i < 16; i++) begin
      model[i] = (32'(i) * 32'h01010101) ^ 32'h5A000000;
      access(0, 1'b1, 32'(i) << 2, 4'hF, model[i], rd);
    end
    for (int n = 0; n < 40; n++) begin
      int          wi;
      logic        w;
      logic [3:0]  m;
      logic [31:0] wd;
      logic [31:0] exp;
      wi  = int'($urandom_range(0, 19));
      w   = 1'($urandom_range(0, 1));
      m   = 4'($urandom_range(0, 15));
      wd  = $urandom;
      exp = 32'h0;
      if (w) begin
        if (wi < 16) begin
          for (int b = 0; b < 4; b++) begin
            if (m[b]) model[wi][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end else if (wi < 16) begin
        exp = model[wi];
      end
      access(0, w, 32'(wi) << 2, m, wd, rd);
      chk($sformatf("rand%0d_rdata", n), rd, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
